// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for heap-ordered binary PLRU trees.
package plru_pkg;

    typedef enum logic [0:0] {INIT, IDLE} plru_state_e;

    // Heap index of the node at depth lvl on the root-to-leaf path of way.
    function automatic int unsigned node_idx(int unsigned lvl, int unsigned way,
                                             int unsigned idx_w);
        return ((32'd1 << lvl) - 32'd1) + (way >> (idx_w - lvl));
    endfunction

    // Direction taken by way at depth lvl (MSB of the way index at the root).
    function automatic logic path_bit(int unsigned lvl, int unsigned way,
                                      int unsigned idx_w);
        return ((way >> (idx_w - 1 - lvl)) & 32'd1) != 32'd0;
    endfunction

endpackage

// File: rtl/plru_set_array_if.sv
// Touch, victim-query and response bundle between a cache controller and plru_set_array.
interface plru_set_array_if #(
    parameter int unsigned WAYS = 8,
    parameter int unsigned SETS = 64
);
    localparam int unsigned WayIdxW = $clog2(WAYS);
    localparam int unsigned SetIdxW = $clog2(SETS);

    logic               flush_i;
    logic               busy_o;
    logic               upd_valid_i;
    logic [SetIdxW-1:0] upd_set_i;
    logic [WayIdxW-1:0] upd_way_i;
    logic               qry_valid_i;
    logic               qry_ready_o;
    logic [SetIdxW-1:0] qry_set_i;
    logic [WAYS-1:0]    qry_way_valid_i;
    logic [WAYS-1:0]    qry_lock_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [WayIdxW-1:0] rsp_way_o;
    logic [WAYS-1:0]    rsp_onehot_o;
    logic               rsp_none_o;

    modport master (
        output flush_i, upd_valid_i, upd_set_i, upd_way_i, qry_valid_i, qry_set_i,
               qry_way_valid_i, qry_lock_i, rsp_ready_i,
        input  busy_o, qry_ready_o, rsp_valid_o, rsp_way_o, rsp_onehot_o, rsp_none_o
    );

    modport slave (
        input  flush_i, upd_valid_i, upd_set_i, upd_way_i, qry_valid_i, qry_set_i,
               qry_way_valid_i, qry_lock_i, rsp_ready_i,
        output busy_o, qry_ready_o, rsp_valid_o, rsp_way_o, rsp_onehot_o, rsp_none_o
    );
endinterface

// File: rtl/plru_masked_select.sv
// Combinational PLRU victim pick for one tree: free unlocked ways first, then a lock-aware walk.
module plru_masked_select #(
    parameter int unsigned WAYS = 8,
    localparam int unsigned WayIdxW = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]    tree_i,
    input  logic [WAYS-1:0]    way_valid_i,
    input  logic [WAYS-1:0]    lock_i,
    output logic [WayIdxW-1:0] way_o,
    output logic [WAYS-1:0]    onehot_o,
    output logic               none_o
);
    logic        found;
    logic        avail;
    int unsigned prefix;
    int unsigned node;
    int unsigned dir;

    always_comb begin
        none_o   = &lock_i;
        way_o    = '0;
        onehot_o = '0;
        found    = 1'b0;
        avail    = 1'b0;
        prefix   = 0;
        node     = 0;
        dir      = 0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found && !way_valid_i[i] && !lock_i[i]) begin
                found  = 1'b1;
                prefix = i;
            end
        end
        if (!found) begin
            // prefix accumulates the path; a side with no unlocked leaf is never entered.
            for (int unsigned lvl = 0; lvl < WayIdxW; lvl++) begin
                node  = ((32'd1 << lvl) - 32'd1) + prefix;
                dir   = 32'(tree_i[node]);
                avail = 1'b0;
                for (int unsigned i = 0; i < WAYS; i++) begin
                    if ((i >> (WayIdxW - 1 - lvl)) == (prefix * 2 + dir) && !lock_i[i]) begin
                        avail = 1'b1;
                    end
                end
                if (!avail) dir = 32'd1 - dir;
                prefix = prefix * 2 + dir;
            end
        end
        if (!none_o) begin
            way_o            = WayIdxW'(prefix);
            onehot_o[prefix] = 1'b1;
        end
    end
endmodule

// File: rtl/plru_set_array.sv
// SETS independent PLRU trees with masked victim query, registered response and init/flush sweep.
module plru_set_array
    import plru_pkg::*;
#(
    parameter int unsigned WAYS       = 8,
    parameter int unsigned SETS       = 64,
    parameter bit          AUTO_TOUCH = 1'b1
) (
    input logic             clk_i,
    input logic             rst_i,
    plru_set_array_if.slave bus
);
    localparam int unsigned WayIdxW = $clog2(WAYS);
    localparam int unsigned SetIdxW = $clog2(SETS);

    typedef logic [WAYS-2:0] tree_t;

    tree_t              tree_mem [SETS];
    plru_state_e        state_q, state_d;
    logic [SetIdxW-1:0] cnt_q, cnt_d;

    logic               busy, qry_ready, accept, upd_en, same_set, auto_en;
    tree_t              qry_raw, qry_tree, auto_tree, upd_tree;
    logic [WayIdxW-1:0] sel_way;
    logic [WAYS-1:0]    sel_onehot;
    logic               sel_none;

    logic               rsp_valid_q;
    logic [WayIdxW-1:0] rsp_way_q;
    logic [WAYS-1:0]    rsp_onehot_q;
    logic               rsp_none_q;

    function automatic tree_t touch(tree_t t, logic [WayIdxW-1:0] w);
        tree_t r = t;
        for (int unsigned lvl = 0; lvl < WayIdxW; lvl++) begin
            r[node_idx(lvl, 32'(w), WayIdxW)] = ~path_bit(lvl, 32'(w), WayIdxW);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (bus.flush_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SetIdxW'(SETS - 1)) state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign busy      = (state_q == INIT);
    assign qry_ready = !busy && (!rsp_valid_q || bus.rsp_ready_i);
    assign accept    = bus.qry_valid_i && qry_ready;
    assign upd_en    = bus.upd_valid_i && !busy;
    assign same_set  = upd_en && (bus.upd_set_i == bus.qry_set_i);
    assign auto_en   = AUTO_TOUCH && accept && !sel_none;

    // The query sees a same-cycle update; on a shared set the explicit touch lands last.
    always_comb begin
        qry_raw   = tree_mem[bus.qry_set_i];
        qry_tree  = same_set ? touch(qry_raw, bus.upd_way_i) : qry_raw;
        auto_tree = touch(qry_raw, sel_way);
        if (same_set) auto_tree = touch(auto_tree, bus.upd_way_i);
        upd_tree  = touch(tree_mem[bus.upd_set_i], bus.upd_way_i);
    end

    plru_masked_select #(
        .WAYS(WAYS)
    ) u_select (
        .tree_i     (qry_tree),
        .way_valid_i(bus.qry_way_valid_i),
        .lock_i     (bus.qry_lock_i),
        .way_o      (sel_way),
        .onehot_o   (sel_onehot),
        .none_o     (sel_none)
    );

    always_ff @(posedge clk_i) begin
        if (busy) begin
            tree_mem[cnt_q] <= '0;
        end else begin
            if (upd_en)  tree_mem[bus.upd_set_i] <= upd_tree;
            if (auto_en) tree_mem[bus.qry_set_i] <= auto_tree;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_way_q    <= '0;
            rsp_onehot_q <= '0;
            rsp_none_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_way_q    <= sel_way;
            rsp_onehot_q <= sel_onehot;
            rsp_none_q   <= sel_none;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.busy_o       = busy;
    assign bus.qry_ready_o  = qry_ready;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_way_o    = rsp_way_q;
    assign bus.rsp_onehot_o = rsp_onehot_q;
    assign bus.rsp_none_o   = rsp_none_q;
endmodule
